// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: merges single-cycle pipeline write-back with queued
// multicycle (mul/div) results, and reports in-flight writes for hazard detection.
module wb_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_valid,
    input  logic [4:0]               pipe_adr,
    input  logic [31:0]              pipe_data,
    input  logic                     mc_valid,
    output logic                     mc_ready,
    input  logic [4:0]               mc_adr,
    input  logic [31:0]              mc_data,
    output logic                     regWrite,
    output logic [4:0]               writeAdr,
    output logic [31:0]              writeData,
    input  logic [4:0]               lookup_adr1,
    input  logic [4:0]               lookup_adr2,
    output logic                     pending1,
    output logic                     pending2,
    output logic                     stall_req,
    output logic                     overrun,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       mem_adr  [DEPTH];
    logic [31:0]      mem_data [DEPTH];
    logic [DEPTH-1:0] slot_valid;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [SC_W-1:0]  starve_cnt;

    logic fifo_nonempty;
    logic push;
    logic pop;
    logic issue_pipe;
    logic drop_pipe;

    assign mc_ready      = (fifo_count < CNT_W'(DEPTH));
    assign fifo_nonempty = (fifo_count != '0);
    assign stall_req     = (starve_cnt >= SC_W'(STARVE_LIMIT));
    // Writes to $zero complete the handshake but are never queued.
    assign push          = mc_valid & mc_ready & (mc_adr != 5'd0);

    always_comb begin
        pop        = 1'b0;
        issue_pipe = 1'b0;
        drop_pipe  = 1'b0;
        if (stall_req && fifo_nonempty) begin
            pop       = 1'b1;
            drop_pipe = pipe_valid;
        end else if (pipe_valid && (pipe_adr != 5'd0)) begin
            issue_pipe = 1'b1;
        end else if (fifo_nonempty) begin
            pop = 1'b1;
        end
    end

    // Storage needs no reset: slot_valid alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_adr[wr_ptr]  <= mc_adr;
            mem_data[wr_ptr] <= mc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            slot_valid <= '0;
            fifo_count <= '0;
            starve_cnt <= '0;
            overrun    <= 1'b0;
            regWrite   <= 1'b0;
            writeAdr   <= 5'd0;
            writeData  <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr             <= wr_ptr + 1'b1;
                slot_valid[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr             <= rd_ptr + 1'b1;
                slot_valid[rd_ptr] <= 1'b0;
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            if (pop || !fifo_nonempty) begin
                starve_cnt <= '0;
            end else if (issue_pipe && (starve_cnt < SC_W'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (drop_pipe) begin
                overrun <= 1'b1;
            end

            regWrite <= issue_pipe | pop;
            if (issue_pipe) begin
                writeAdr  <= pipe_adr;
                writeData <= pipe_data;
            end else if (pop) begin
                writeAdr  <= mem_adr[rd_ptr];
                writeData <= mem_data[rd_ptr];
            end
        end
    end

    // Same-cycle mc/pipe inputs are deliberately excluded from the hazard view.
    always_comb begin
        pending1 = regWrite && (writeAdr == lookup_adr1);
        pending2 = regWrite && (writeAdr == lookup_adr2);
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && (mem_adr[i] == lookup_adr1)) pending1 = 1'b1;
            if (slot_valid[i] && (mem_adr[i] == lookup_adr2)) pending2 = 1'b1;
        end
        if (lookup_adr1 == 5'd0) pending1 = 1'b0;
        if (lookup_adr2 == 5'd0) pending2 = 1'b0;
    end

endmodule
